gpio_serial_loader: RTL and testbench



---
 rtl/gpio_cfg_pkg.sv | 27 ++
 rtl/gpio_serial_loader_if.sv | 26 ++
 rtl/gpio_serial_tick.sv | 22 ++
 rtl/gpio_serial_loader.sv | 104 ++++++++++
 tb/tb_gpio_serial_loader.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_cfg_pkg.sv
// Shared pad-configuration constants and the serial loader state encoding.
// Bit offsets must stay in step with the gpio_control_block word layout.
package gpio_cfg_pkg;
   localparam int PAD_CTRL_BITS_DFLT = 13;

   localparam int MGMT_EN_OFS = 0;
   localparam int OEB_OFS     = 1;
   localparam int HLDH_OFS    = 2;
   localparam int INP_DIS_OFS = 3;
   localparam int MOD_SEL_OFS = 4;
   localparam int AN_EN_OFS   = 5;
   localparam int AN_SEL_OFS  = 6;
   localparam int AN_POL_OFS  = 7;
   localparam int SLOW_OFS    = 8;
   localparam int VTRIP_OFS   = 9;
   localparam int DM_OFS      = 10;
   localparam int DM_BITS     = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOW,
      ST_HIGH,
      ST_LOAD,
      ST_LOADEND
   } loader_state_e;
endpackage

// File: rtl/gpio_serial_loader_if.sv
// Register-file fetch port, start/status handshake and serial chain head signals.
interface gpio_serial_loader_if #(
   parameter int NUM_GPIO      = 19,
   parameter int PAD_CTRL_BITS = 13
);
   localparam int IDX_W = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1;

   logic                     start;
   logic [IDX_W-1:0]         cfg_idx;
   logic [PAD_CTRL_BITS-1:0] cfg_data;
   logic                     serial_clock;
   logic                     serial_load;
   logic                     serial_data;
   logic                     busy;
   logic                     done;

   modport master (
      input  start, cfg_data,
      output cfg_idx, serial_clock, serial_load, serial_data, busy, done
   );

   modport slave (
      output start, cfg_data,
      input  cfg_idx, serial_clock, serial_load, serial_data, busy, done
   );
endinterface

// File: rtl/gpio_serial_tick.sv
// Phase divider: counts 0..CLK_DIV-1 and flags the last cycle of a phase.
module gpio_serial_tick #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic phase_last
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   cnt <= '0;
      else if (clear || phase_last) cnt <= '0;
      else                          cnt <= cnt + CW'(1);
   end

   assign phase_last = (cnt == CNT_LAST);
endmodule

// File: rtl/gpio_serial_loader.sv
// Shifts one config word per GPIO into the daisy chain (farthest block first,
// MSB first), then strobes serial_load so every block latches together.
module gpio_serial_loader
   import gpio_cfg_pkg::*;
#(
   parameter int PAD_CTRL_BITS = PAD_CTRL_BITS_DFLT,
   parameter int NUM_GPIO      = 19,
   parameter int CLK_DIV       = 2
) (
   input  logic               wb_clk_i,
   input  logic               wb_rstn_i,
   gpio_serial_loader_if.master bus
);
   localparam int IDX_W = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1;
   localparam int CNT_W = (PAD_CTRL_BITS > 1) ? $clog2(PAD_CTRL_BITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_GPIO - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(PAD_CTRL_BITS - 1);

   loader_state_e            state, state_d;
   logic [IDX_W-1:0]         idx, idx_d;
   logic [CNT_W-1:0]         bit_cnt, bit_cnt_d;
   logic [PAD_CTRL_BITS-1:0] shreg, shreg_d;
   logic                     phase_last, done_d;

   gpio_serial_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk        (wb_clk_i),
      .rst_n      (wb_rstn_i),
      .clear      (state_d != state),
      .phase_last (phase_last)
   );

   // A start coinciding with done is dropped: the sequence is not yet considered idle.
   always_comb begin
      state_d   = state;
      idx_d     = idx;
      bit_cnt_d = bit_cnt;
      shreg_d   = shreg;
      done_d    = 1'b0;
      unique case (state)
         ST_IDLE:
            if (bus.start && !bus.done) begin
               state_d   = ST_FETCH;
               idx_d     = IDX_LAST;
               bit_cnt_d = BIT_LAST;
            end
         ST_FETCH: begin
            shreg_d = bus.cfg_data;
            state_d = ST_LOW;
         end
         ST_LOW:
            if (phase_last) state_d = ST_HIGH;
         ST_HIGH:
            if (phase_last) begin
               if (bit_cnt != '0) begin
                  shreg_d   = shreg << 1;
                  bit_cnt_d = bit_cnt - CNT_W'(1);
                  state_d   = ST_LOW;
               end else if (idx != '0) begin
                  idx_d     = idx - IDX_W'(1);
                  bit_cnt_d = BIT_LAST;
                  state_d   = ST_FETCH;
               end else begin
                  state_d   = ST_LOAD;
               end
            end
         ST_LOAD:
            if (phase_last) state_d = ST_LOADEND;
         ST_LOADEND:
            if (phase_last) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from next-state so every chain-facing pin is a flop.
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         state            <= ST_IDLE;
         idx              <= '0;
         bit_cnt          <= '0;
         shreg            <= '0;
         bus.serial_clock <= 1'b0;
         bus.serial_load  <= 1'b0;
         bus.serial_data  <= 1'b0;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
      end else begin
         state            <= state_d;
         idx              <= idx_d;
         bit_cnt          <= bit_cnt_d;
         shreg            <= shreg_d;
         bus.serial_clock <= (state_d == ST_HIGH);
         bus.serial_load  <= (state_d == ST_LOAD);
         bus.serial_data  <= (state_d == ST_LOW || state_d == ST_HIGH) ?
                             shreg_d[PAD_CTRL_BITS-1] : 1'b0;
         bus.busy         <= (state_d != ST_IDLE);
         bus.done         <= done_d;
      end
   end

   assign bus.cfg_idx = idx;
endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench: two loaders (CLK_DIV 1 and 3) each driving a two-block chain model.
module tb_gpio_serial_loader;
   import gpio_cfg_pkg::*;

   localparam int NG = 2;
   localparam int PB = PAD_CTRL_BITS_DFLT;
   localparam int NE = NG * PB;

   logic wb_clk_i = 1'b0;
   logic wb_rstn_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   gpio_serial_loader_if #(.NUM_GPIO(NG), .PAD_CTRL_BITS(PB)) ifa ();
   gpio_serial_loader_if #(.NUM_GPIO(NG), .PAD_CTRL_BITS(PB)) ifb ();

   logic [NG-1:0][PB-1:0] cfg_a = '0, cfg_b = '0;
   logic start_a = 1'b0, start_b = 1'b0;
   assign ifa.start    = start_a;
   assign ifa.cfg_data = cfg_a[ifa.cfg_idx];
   assign ifb.start    = start_b;
   assign ifb.cfg_data = cfg_b[ifb.cfg_idx];

   gpio_serial_loader #(.PAD_CTRL_BITS(PB), .NUM_GPIO(NG), .CLK_DIV(1)) dut_a (
      .wb_clk_i (wb_clk_i), .wb_rstn_i (wb_rstn_i), .bus (ifa));
   gpio_serial_loader #(.PAD_CTRL_BITS(PB), .NUM_GPIO(NG), .CLK_DIV(3)) dut_b (
      .wb_clk_i (wb_clk_i), .wb_rstn_i (wb_rstn_i), .bus (ifb));

   // Chain models: block 0 is the head, its shifted-out MSB feeds block 1.
   logic [NG-1:0][PB-1:0] sh_a = '0, lat_a = '0, sh_b = '0, lat_b = '0;
   always @(posedge ifa.serial_clock) begin
      sh_a[0] <= {sh_a[0][PB-2:0], ifa.serial_data};
      sh_a[1] <= {sh_a[1][PB-2:0], sh_a[0][PB-1]};
   end
   always @(posedge ifa.serial_load) lat_a <= sh_a;
   always @(posedge ifb.serial_clock) begin
      sh_b[0] <= {sh_b[0][PB-2:0], ifb.serial_data};
      sh_b[1] <= {sh_b[1][PB-2:0], sh_b[0][PB-1]};
   end
   always @(posedge ifb.serial_load) lat_b <= sh_b;

   logic mon_clr = 1'b1;
   int edges_a = 0, loads_a = 0, busy_a = 0, dones_a = 0;
   logic [NE-1:0] bits_a = '0;
   logic sc_prev_a = 1'b0, ld_prev_a = 1'b0;
   always @(negedge wb_clk_i) begin
      if (mon_clr) begin
         edges_a <= 0; loads_a <= 0; busy_a <= 0; dones_a <= 0; bits_a <= '0;
      end else begin
         if (ifa.serial_clock && !sc_prev_a) begin
            if (edges_a < NE) bits_a[edges_a] <= ifa.serial_data;
            edges_a <= edges_a + 1;
         end
         if (ifa.serial_load && !ld_prev_a) loads_a <= loads_a + 1;
         if (ifa.busy) busy_a <= busy_a + 1;
         if (ifa.done) dones_a <= dones_a + 1;
      end
      sc_prev_a <= ifa.serial_clock;
      ld_prev_a <= ifa.serial_load;
   end

   int edges_b = 0, busy_b = 0, hi_cyc_b = 0, hi_run_b = 0, hi_bad_b = 0;
   int lo_run_b = 0, lo3_b = 0, lo4_b = 0, dat_bad_b = 0;
   logic sc_prev_b = 1'b0, sd_prev_b = 1'b0;
   always @(negedge wb_clk_i) begin
      if (mon_clr) begin
         edges_b <= 0; busy_b <= 0; hi_cyc_b <= 0; hi_run_b <= 0; hi_bad_b <= 0;
         lo_run_b <= 0; lo3_b <= 0; lo4_b <= 0; dat_bad_b <= 0;
      end else begin
         if (ifb.busy) busy_b <= busy_b + 1;
         if (ifb.serial_clock) begin
            hi_cyc_b <= hi_cyc_b + 1;
            hi_run_b <= hi_run_b + 1;
            if (ifb.serial_data != sd_prev_b) dat_bad_b <= dat_bad_b + 1;
            if (!sc_prev_b) begin
               edges_b  <= edges_b + 1;
               lo_run_b <= 0;
               if (lo_run_b == 3) lo3_b <= lo3_b + 1;
               if (lo_run_b == 4) lo4_b <= lo4_b + 1;
            end
         end else begin
            if (ifb.busy && !ifb.serial_load) lo_run_b <= lo_run_b + 1;
            if (sc_prev_b) begin
               if (hi_run_b != 3) hi_bad_b <= hi_bad_b + 1;
               hi_run_b <= 0;
            end
         end
      end
      sc_prev_b <= ifb.serial_clock;
      sd_prev_b <= ifb.serial_data;
   end

   int n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   function automatic logic [NE-1:0] bits_exp(input logic [PB-1:0] w1, input logic [PB-1:0] w0);
      logic [NE-1:0] s, r;
      s = {w1, w0};
      for (int k = 0; k < NE; k++) r[k] = s[NE-1-k];
      return r;
   endfunction

   task automatic wait_a(input int bound);
      for (int i = 0; i < bound; i++) begin
         if (ifa.done) break;
         tick();
      end
      chk("done_seen_a", ifa.done, 1'b1);
   endtask

   task automatic go_a(input logic [PB-1:0] w1, input logic [PB-1:0] w0);
      cfg_a[1] = w1; cfg_a[0] = w0;
      mon_clr = 1'b1; tick(); mon_clr = 1'b0;
      start_a = 1'b1; tick(); start_a = 1'b0;
   endtask

   logic [NE-1:0] bits1;
   int busy1, edges1;

   initial begin
      repeat (3) tick();
      chk("rst_sclk", ifa.serial_clock, 1'b0);
      chk("rst_load", ifa.serial_load, 1'b0);
      chk("rst_data", ifa.serial_data, 1'b0);
      chk("rst_busy", ifa.busy, 1'b0);
      chk("rst_done", ifa.done, 1'b0);
      chk("rst_idx", ifa.cfg_idx, 0);
      wb_rstn_i = 1'b1;
      tick();

      // basic load
      go_a(13'h1FFF, 13'h0403); wait_a(200); tick();
      chk("basic_edges", edges_a, 26);
      chk("basic_loads", loads_a, 1);
      chk("basic_busy", busy_a, 56);
      chk("basic_dones", dones_a, 1);
      chk("basic_bits", bits_a, bits_exp(13'h1FFF, 13'h0403));
      chk("basic_blk1", lat_a[1], 13'h1FFF);
      chk("basic_blk0", lat_a[0], 13'h0403);
      chk("basic_mgmt", lat_a[0][MGMT_EN_OFS], 1'b1);
      chk("basic_oeb", lat_a[0][OEB_OFS], 1'b1);
      chk("basic_dm", lat_a[0][DM_OFS +: DM_BITS], 3'b001);

      // bit order
      go_a(13'h1000, 13'h0001); wait_a(200); tick();
      chk("order_bits", bits_a, 26'h2000001);
      chk("order_blk1", lat_a[1], 13'h1000);
      chk("order_blk0", lat_a[0], 13'h0001);

      // start while busy
      go_a(13'h0ABC, 13'h1234);
      repeat (9) tick();
      start_a = 1'b1; tick(); start_a = 1'b0;
      wait_a(200);
      repeat (60) tick();
      chk("busy_start_edges", edges_a, 26);
      chk("busy_start_dones", dones_a, 1);
      chk("busy_start_busy", busy_a, 56);
      chk("busy_start_idle", ifa.busy, 1'b0);
      chk("busy_start_blk1", lat_a[1], 13'h0ABC);

      // reset mid-shift
      go_a(13'h1555, 13'h0AAA);
      for (int i = 0; i < 200 && edges_a < 15; i++) tick();
      chk("mid_edge15", edges_a, 15);
      wb_rstn_i = 1'b0;
      tick();
      chk("mid_sclk", ifa.serial_clock, 1'b0);
      chk("mid_load", ifa.serial_load, 1'b0);
      chk("mid_data", ifa.serial_data, 1'b0);
      chk("mid_busy", ifa.busy, 1'b0);
      chk("mid_done", ifa.done, 1'b0);
      repeat (3) tick();
      chk("mid_no_edges", edges_a, 15);
      chk("mid_no_load", loads_a, 0);
      chk("mid_keep_blk1", lat_a[1], 13'h0ABC);
      chk("mid_keep_blk0", lat_a[0], 13'h1234);
      wb_rstn_i = 1'b1;
      tick();
      go_a(13'h0F0F, 13'h00F0); wait_a(200); tick();
      chk("after_rst_edges", edges_a, 26);
      chk("after_rst_blk1", lat_a[1], 13'h0F0F);
      chk("after_rst_blk0", lat_a[0], 13'h00F0);

      // back-to-back: second start in the cycle after done
      go_a(13'h1A5C, 13'h05A3); wait_a(200);
      bits1 = bits_a; busy1 = busy_a; edges1 = edges_a;
      mon_clr = 1'b1; tick(); mon_clr = 1'b0;
      start_a = 1'b1; tick(); start_a = 1'b0;
      wait_a(200); tick();
      chk("b2b_first_bits", bits1, bits_exp(13'h1A5C, 13'h05A3));
      chk("b2b_first_busy", busy1, 56);
      chk("b2b_bits", bits_a, bits1);
      chk("b2b_busy", busy_a, busy1);
      chk("b2b_edges", edges_a, edges1);
      chk("b2b_loads", loads_a, 1);
      chk("b2b_blk1", lat_a[1], 13'h1A5C);

      // divider, CLK_DIV=3
      cfg_b[1] = 13'h1FFF; cfg_b[0] = 13'h0403;
      mon_clr = 1'b1; tick(); mon_clr = 1'b0;
      start_b = 1'b1; tick(); start_b = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (ifb.done) break;
         tick();
      end
      chk("done_seen_b", ifb.done, 1'b1);
      tick();
      chk("div_busy", busy_b, 164);
      chk("div_edges", edges_b, 26);
      chk("div_hi_cycles", hi_cyc_b, 78);
      chk("div_hi_runs_bad", hi_bad_b, 0);
      chk("div_lo3_runs", lo3_b, 24);
      chk("div_lo4_runs", lo4_b, 2);
      chk("div_data_unstable", dat_bad_b, 0);
      chk("div_blk1", lat_b[1], 13'h1FFF);
      chk("div_blk0", lat_b[0], 13'h0403);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
